// File: rtl/pa_riscv_pkg.sv
// Shared RV32I decode types for the multicycle controller: opcodes, ALU
// operations, datapath select encodings and controller state codes.
package pa_riscv;

   // Opcodes the multicycle core executes; anything else is illegal.
   typedef enum logic [6:0] {
      OP_LW         = 7'b0000011,
      OP_SW         = 7'b0100011,
      OP_R_TYPE_ALU = 7'b0110011,
      OP_I_TYPE_ALU = 7'b0010011,
      OP_B_TYPE     = 7'b1100011,
      OP_JAL        = 7'b1101111
   } ty_OPERAND;

   // ALU operation, encoded as {funct7b5, funct3}.
   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b1000,
      ALU_XOR = 4'b0100,
      ALU_OR  = 4'b0110,
      ALU_AND = 4'b0111
   } ty_ALU_OP;

   typedef enum logic [1:0] {
      RES_ALUOUT    = 2'b00,
      RES_DATA      = 2'b01,
      RES_ALURESULT = 2'b10
   } ty_RESULT_SRC;

   typedef enum logic [1:0] {
      SRCA_PC    = 2'b00,
      SRCA_OLDPC = 2'b01,
      SRCA_REG   = 2'b10
   } ty_ALU_SRC_A;

   typedef enum logic [1:0] {
      SRCB_REG  = 2'b00,
      SRCB_IMM  = 2'b01,
      SRCB_FOUR = 2'b10
   } ty_ALU_SRC_B;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } ty_IMM_SRC;

   // How the ALU decoder should interpret funct3/funct7b5.
   typedef enum logic [1:0] {
      ALU_CLASS_ADD = 2'b00,
      ALU_CLASS_SUB = 2'b01,
      ALU_CLASS_R   = 2'b10,
      ALU_CLASS_I   = 2'b11
   } ty_ALU_CLASS;

   localparam logic [2:0] F3_BEQ   = 3'b000;
   localparam logic [2:0] F3_BNE   = 3'b001;
   localparam logic [2:0] F3_LW_SW = 3'b010;

   // Controller states, kept as plain codes for legacy tools.
   typedef logic [3:0] ty_MC_STATE;
   localparam ty_MC_STATE MC_FETCH    = 4'd0;
   localparam ty_MC_STATE MC_DECODE   = 4'd1;
   localparam ty_MC_STATE MC_MEMADR   = 4'd2;
   localparam ty_MC_STATE MC_MEMREAD  = 4'd3;
   localparam ty_MC_STATE MC_MEMWB    = 4'd4;
   localparam ty_MC_STATE MC_MEMWRITE = 4'd5;
   localparam ty_MC_STATE MC_EXECR    = 4'd6;
   localparam ty_MC_STATE MC_EXECI    = 4'd7;
   localparam ty_MC_STATE MC_ALUWB    = 4'd8;
   localparam ty_MC_STATE MC_BRANCH   = 4'd9;
   localparam ty_MC_STATE MC_JAL      = 4'd10;

   // True when {funct7b5, funct3} names an operation the ALU implements.
   function automatic logic is_alu_op(input logic [3:0] code);
      return code inside {ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND};
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the controller's ALU class plus funct3/funct7b5 to an
// ALU operation and reports whether that combination is a legal encoding.
module alu_decoder
   import pa_riscv::*;
(
   input  logic [1:0] alu_class,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [3:0] alu_op,
   output logic       legal
);

   // Decode the operation; fixed-op classes are always legal.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      alu_op = ALU_ADD;
      legal  = 1'b1;
      case (alu_class)
         ALU_CLASS_ADD: alu_op = ALU_ADD;
         ALU_CLASS_SUB: alu_op = ALU_SUB;
         ALU_CLASS_R: begin
            alu_op = {funct7b5, funct3};
            legal  = is_alu_op({funct7b5, funct3});
         end
         ALU_CLASS_I: begin
            // Immediate forms have no SUB; bit 30 belongs to the immediate.
            alu_op = {1'b0, funct3};
            legal  = funct3 inside {3'b000, 3'b100, 3'b110, 3'b111};
         end
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style main controller of the multicycle RV32I core. Sequences
// fetch/decode/execute/memory/writeback through a shared memory, stalling
// on the memory-ready handshake and flagging illegal encodings.
module multicycle_controller
   import pa_riscv::*;
#(
   parameter bit USE_MEM_READY = 1'b1,
   parameter bit EN_BNE        = 1'b1
)(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_op,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_zero,
   input  logic       i_memReady,
   output logic       o_pcWrite,
   output logic       o_adrSrc,
   output logic       o_memWrite,
   output logic       o_irWrite,
   output logic       o_regWrite,
   output logic [1:0] o_resultSrc,
   output logic [1:0] o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [1:0] o_immSrc,
   output logic [3:0] o_aluControl,
   output logic       o_illegal,
   output logic       o_instret
);

   ty_MC_STATE state;
   ty_MC_STATE state_next;
   logic       ready;
   logic [1:0] alu_class;
   logic [3:0] dec_alu_op;
   logic       dec_legal;
   logic       op_legal;

   assign ready = USE_MEM_READY ? i_memReady : 1'b1;

   // Pick the ALU decoding class: from the opcode while decoding, else from the state.
   always_comb begin
      alu_class = ALU_CLASS_ADD;
      case (state)
         MC_DECODE: begin
            if (i_op == OP_R_TYPE_ALU)      alu_class = ALU_CLASS_R;
            else if (i_op == OP_I_TYPE_ALU) alu_class = ALU_CLASS_I;
         end
         MC_EXECR:  alu_class = ALU_CLASS_R;
         MC_EXECI:  alu_class = ALU_CLASS_I;
         MC_BRANCH: alu_class = ALU_CLASS_SUB;
         default:   alu_class = ALU_CLASS_ADD;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_class (alu_class),
      .funct3    (i_funct3),
      .funct7b5  (i_funct7b5),
      .alu_op    (dec_alu_op),
      .legal     (dec_legal)
   );

   // Legality of the held instruction, judged from its opcode and function fields.
   always_comb begin
      op_legal = 1'b0;
      case (i_op)
         OP_LW, OP_SW:                 op_legal = (i_funct3 == F3_LW_SW);
         OP_R_TYPE_ALU, OP_I_TYPE_ALU: op_legal = dec_legal;
         OP_B_TYPE:                    op_legal = (i_funct3 == F3_BEQ) ||
                                                  (EN_BNE && (i_funct3 == F3_BNE));
         OP_JAL:                       op_legal = 1'b1;
         default:                      op_legal = 1'b0;
      endcase
   end

   // Next-state logic; ready only matters in FETCH, MEMREAD and MEMWRITE.
   always_comb begin
      state_next = state;
      case (state)
         MC_FETCH:  if (ready) state_next = MC_DECODE;
         MC_DECODE: begin
            state_next = MC_FETCH;
            if (op_legal) begin
               case (i_op)
                  OP_LW, OP_SW:  state_next = MC_MEMADR;
                  OP_R_TYPE_ALU: state_next = MC_EXECR;
                  OP_I_TYPE_ALU: state_next = MC_EXECI;
                  OP_B_TYPE:     state_next = MC_BRANCH;
                  OP_JAL:        state_next = MC_JAL;
                  default:       state_next = MC_FETCH;
               endcase
            end
         end
         MC_MEMADR:   state_next = (i_op == OP_SW) ? MC_MEMWRITE : MC_MEMREAD;
         MC_MEMREAD:  if (ready) state_next = MC_MEMWB;
         MC_MEMWRITE: if (ready) state_next = MC_FETCH;
         MC_EXECR, MC_EXECI, MC_JAL:        state_next = MC_ALUWB;
         MC_MEMWB, MC_ALUWB, MC_BRANCH:     state_next = MC_FETCH;
         default:     state_next = MC_FETCH;
      endcase
   end

   // State register; reset forces FETCH at once, dropping any pending strobe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (i_rst) state <= MC_FETCH;
      else       state <= state_next;
   end

   // Datapath controls decoded from the state and the held IR fields.
   always_comb begin
      o_pcWrite    = 1'b0;
      o_adrSrc     = 1'b0;
      o_memWrite   = 1'b0;
      o_irWrite    = 1'b0;
      o_regWrite   = 1'b0;
      o_resultSrc  = RES_ALUOUT;
      o_aluSrcA    = SRCA_PC;
      o_aluSrcB    = SRCB_REG;
      o_immSrc     = IMM_I;
      o_aluControl = ALU_ADD;
      o_illegal    = 1'b0;
      o_instret    = 1'b0;
      case (state)
         MC_FETCH: begin
            o_irWrite   = ready;
            o_pcWrite   = ready;
            o_aluSrcB   = SRCB_FOUR;
            o_resultSrc = RES_ALURESULT;
         end
         MC_DECODE: begin
            // Branch target is computed here so BRANCH can load it from ALUOut.
            o_aluSrcA = SRCA_OLDPC;
            o_aluSrcB = SRCB_IMM;
            o_immSrc  = IMM_B;
            o_illegal = ~op_legal;
         end
         MC_MEMADR: begin
            o_aluSrcA = SRCA_REG;
            o_aluSrcB = SRCB_IMM;
            o_immSrc  = (i_op == OP_SW) ? IMM_S : IMM_I;
         end
         MC_MEMREAD: o_adrSrc = 1'b1;
         MC_MEMWRITE: begin
            o_adrSrc   = 1'b1;
            o_memWrite = 1'b1;
            o_instret  = ready;
         end
         MC_MEMWB: begin
            o_resultSrc = RES_DATA;
            o_regWrite  = 1'b1;
            o_instret   = 1'b1;
         end
         MC_EXECR: begin
            o_aluSrcA    = SRCA_REG;
            o_aluSrcB    = SRCB_REG;
            o_aluControl = dec_alu_op;
         end
         MC_EXECI: begin
            o_aluSrcA    = SRCA_REG;
            o_aluSrcB    = SRCB_IMM;
            o_immSrc     = IMM_I;
            o_aluControl = dec_alu_op;
         end
         MC_ALUWB: begin
            o_regWrite = 1'b1;
            o_instret  = 1'b1;
         end
         MC_BRANCH: begin
            o_aluSrcA    = SRCA_REG;
            o_aluSrcB    = SRCB_REG;
            o_aluControl = dec_alu_op;
            o_pcWrite    = (i_funct3 == F3_BNE) ? ~i_zero : i_zero;
            o_instret    = 1'b1;
         end
         MC_JAL: begin
            o_aluSrcA = SRCA_OLDPC;
            o_aluSrcB = SRCB_FOUR;
            o_immSrc  = IMM_J;
            o_pcWrite = 1'b1;
         end
         default: o_aluControl = ALU_ADD;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. A per-instruction model
// expands each instruction into its expected cycle-by-cycle control
// pattern (from opcode, fields, zero flag and chosen wait counts) and every
// cycle of the DUT is compared against it.
module tb_multicycle_controller;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BT  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic       regw;
      logic [1:0] rsrc;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] imm;
      logic [3:0] alu;
      logic       ill;
      logic       ret;
   } outs_t;

   // rdy: 0/1 = value driven on a sampled cycle, 2 = random (ignored by DUT)
   typedef struct {
      outs_t o;
      int    rdy;
   } cyc_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] f3;
   logic       f7;
   logic       zero;
   logic       mem_ready;
   logic       sel_b;

   int tests = 0;
   int fails = 0;
   cyc_t plan[$];

   logic       a_pcw, a_adr, a_memw, a_irw, a_regw, a_ill, a_ret;
   logic [1:0] a_rsrc, a_srca, a_srcb, a_imm;
   logic [3:0] a_alu;
   logic       b_pcw, b_adr, b_memw, b_irw, b_regw, b_ill, b_ret;
   logic [1:0] b_rsrc, b_srca, b_srcb, b_imm;
   logic [3:0] b_alu;
   outs_t      outs_a, outs_b, obs;

   always #5 clk = ~clk;

   multicycle_controller dut_a (
      .i_clk(clk), .i_rst(rst), .i_op(op), .i_funct3(f3), .i_funct7b5(f7),
      .i_zero(zero), .i_memReady(mem_ready),
      .o_pcWrite(a_pcw), .o_adrSrc(a_adr), .o_memWrite(a_memw), .o_irWrite(a_irw),
      .o_regWrite(a_regw), .o_resultSrc(a_rsrc), .o_aluSrcA(a_srca), .o_aluSrcB(a_srcb),
      .o_immSrc(a_imm), .o_aluControl(a_alu), .o_illegal(a_ill), .o_instret(a_ret)
   );

   multicycle_controller #(.USE_MEM_READY(1'b0), .EN_BNE(1'b0)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_op(op), .i_funct3(f3), .i_funct7b5(f7),
      .i_zero(zero), .i_memReady(mem_ready),
      .o_pcWrite(b_pcw), .o_adrSrc(b_adr), .o_memWrite(b_memw), .o_irWrite(b_irw),
      .o_regWrite(b_regw), .o_resultSrc(b_rsrc), .o_aluSrcA(b_srca), .o_aluSrcB(b_srcb),
      .o_immSrc(b_imm), .o_aluControl(b_alu), .o_illegal(b_ill), .o_instret(b_ret)
   );

   assign outs_a = {a_pcw, a_adr, a_memw, a_irw, a_regw, a_rsrc, a_srca, a_srcb, a_imm, a_alu, a_ill, a_ret};
   assign outs_b = {b_pcw, b_adr, b_memw, b_irw, b_regw, b_rsrc, b_srca, b_srcb, b_imm, b_alu, b_ill, b_ret};
   assign obs    = sel_b ? outs_b : outs_a;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Architectural legality rules of the supported RV32I subset.
   function automatic bit legal_instr(input logic [6:0] o, input logic [2:0] f,
                                      input logic f7b, input bit en_bne);
      case (o)
         LW, SW: return f == 3'b010;
         RT:     return {f7b, f} inside {4'b0000, 4'b1000, 4'b0100, 4'b0110, 4'b0111};
         IT:     return f inside {3'b000, 3'b100, 3'b110, 3'b111};
         BT:     return (f == 3'b000) || (f == 3'b001 && en_bne);
         JL:     return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic outs_t fetch_cyc(input logic rdy);
      outs_t e = '0;
      e.srcb = 2'b10;
      e.rsrc = 2'b10;
      e.pcw  = rdy;
      e.irw  = rdy;
      return e;
   endfunction

   function automatic outs_t wb_cyc(input logic [1:0] rsrc);
      outs_t e = '0;
      e.rsrc = rsrc;
      e.regw = 1'b1;
      e.ret  = 1'b1;
      return e;
   endfunction

   task automatic push(input outs_t e, input int rdy);
      cyc_t c;
      c.o   = e;
      c.rdy = rdy;
      plan.push_back(c);
   endtask

   // Expand one instruction into its expected control pattern.
   task automatic build(input logic [6:0] o, input logic [2:0] f, input logic f7b,
                        input logic z, input bit en_bne, input int wf, input int wm,
                        input bit free);
      outs_t e;
      bit    lg;
      lg = legal_instr(o, f, f7b, en_bne);
      plan.delete();
      for (int i = 0; i < wf; i++) push(fetch_cyc(1'b0), free ? 2 : 0);
      push(fetch_cyc(1'b1), free ? 2 : 1);
      e = '0; e.srca = 2'b01; e.srcb = 2'b01; e.imm = 2'b10; e.ill = !lg;
      push(e, 2);
      if (!lg) return;
      case (o)
         LW: begin
            e = '0; e.srca = 2'b10; e.srcb = 2'b01; e.imm = 2'b00; push(e, 2);
            e = '0; e.adr = 1'b1;
            for (int i = 0; i < wm; i++) push(e, free ? 2 : 0);
            push(e, free ? 2 : 1);
            push(wb_cyc(2'b01), 2);
         end
         SW: begin
            e = '0; e.srca = 2'b10; e.srcb = 2'b01; e.imm = 2'b01; push(e, 2);
            e = '0; e.adr = 1'b1; e.memw = 1'b1;
            for (int i = 0; i < wm; i++) push(e, free ? 2 : 0);
            e.ret = 1'b1;
            push(e, free ? 2 : 1);
         end
         RT: begin
            e = '0; e.srca = 2'b10; e.srcb = 2'b00; e.alu = {f7b, f}; push(e, 2);
            push(wb_cyc(2'b00), 2);
         end
         IT: begin
            e = '0; e.srca = 2'b10; e.srcb = 2'b01; e.imm = 2'b00; e.alu = {1'b0, f}; push(e, 2);
            push(wb_cyc(2'b00), 2);
         end
         BT: begin
            e = '0; e.srca = 2'b10; e.srcb = 2'b00; e.alu = 4'b1000;
            e.pcw = (f == 3'b000) ? z : !z; e.ret = 1'b1; push(e, 2);
         end
         default: begin // JAL
            e = '0; e.srca = 2'b01; e.srcb = 2'b10; e.imm = 2'b11; e.pcw = 1'b1; push(e, 2);
            push(wb_cyc(2'b00), 2);
         end
      endcase
   endtask

   // Drive one instruction and compare every cycle; max_cyc < 0 runs it to completion.
   task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f,
                            input logic f7b, input logic z, input bit en_bne,
                            input int wf, input int wm, input bit free, input int max_cyc);
      int n;
      int n_ret;
      int n_memw;
      bit lg;
      lg = legal_instr(o, f, f7b, en_bne);
      build(o, f, f7b, z, en_bne, wf, wm, free);
      n = (max_cyc >= 0 && max_cyc < plan.size()) ? max_cyc : plan.size();
      n_ret = 0;
      n_memw = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) begin
            op = o; f3 = f; f7 = f7b; zero = z;
         end
         mem_ready = (plan[i].rdy == 2) ? 1'($urandom_range(0, 1)) : 1'(plan[i].rdy);
         #2;
         check($sformatf("%s c%0d", tag, i), 32'(obs), 32'(plan[i].o));
         n_ret  += int'(obs.ret);
         n_memw += int'(obs.memw);
      end
      if (n == plan.size()) begin
         check($sformatf("%s retire_count", tag), n_ret, lg ? 1 : 0);
         check($sformatf("%s memwrite_cycles", tag), n_memw, (lg && o == SW) ? wm + 1 : 0);
      end
   endtask

   initial begin
      int k;
      logic [6:0] ro;
      logic [2:0] rf;
      rst = 1'b1; op = '0; f3 = '0; f7 = 1'b0; zero = 1'b0; mem_ready = 1'b0; sel_b = 1'b0;
      #12;
      check("reset_a", 32'(outs_a), 32'(fetch_cyc(1'b0)));
      @(posedge clk); #1 rst = 1'b0;

      // Directed cases on the default configuration.
      run_instr("add",      RT, 3'b000, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);
      run_instr("lw",       LW, 3'b010, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);
      run_instr("bne_nz",   BT, 3'b001, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);
      run_instr("beq_z",    BT, 3'b000, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0, -1);
      run_instr("sw_wait3", SW, 3'b010, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, -1);
      run_instr("op_zero",  7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);
      run_instr("sub",      RT, 3'b000, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, -1);
      run_instr("addi_f7",  IT, 3'b000, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, -1);
      run_instr("jal",      JL, 3'b101, 1'b1, 1'b0, 1'b1, 2, 0, 1'b0, -1);
      run_instr("lw_waits", LW, 3'b010, 1'b0, 1'b0, 1'b1, 2, 3, 1'b0, -1);

      // Reset while the SW strobe is held: strobe must drop at once.
      run_instr("rst_sw", SW, 3'b010, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, 4);
      #1 rst = 1'b1;
      #1 check("rst_mid_memwrite", 32'(outs_a), 32'(fetch_cyc(1'b0)));
      @(posedge clk); #1 rst = 1'b0;
      run_instr("after_rst", RT, 3'b111, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, -1);

      // Randomized instruction stream with random wait states.
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 7);
         case (k)
            0: ro = LW;  1: ro = SW;  2: ro = RT;  3: ro = IT;  4: ro = BT;  5: ro = JL;
            default: ro = 7'($urandom);
         endcase
         rf = 3'($urandom);
         if (k < 2 && $urandom_range(0, 1) == 1) rf = 3'b010;
         if (k == 4 && $urandom_range(0, 1) == 1) rf = 3'($urandom_range(0, 1));
         run_instr($sformatf("rnd%0d", i), ro, rf, 1'($urandom), 1'($urandom), 1'b1,
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, -1);
      end

      // Second configuration: ready ignored, BNE disabled.
      rst = 1'b1;
      sel_b = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      run_instr("b_bne",  BT, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, -1);
      run_instr("b_beq",  BT, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, -1);
      run_instr("b_sw",   SW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, -1);
      run_instr("b_lw",   LW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, -1);
      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 7);
         case (k)
            0: ro = LW;  1: ro = SW;  2: ro = RT;  3: ro = IT;  4: ro = BT;  5: ro = JL;
            default: ro = 7'($urandom);
         endcase
         rf = 3'($urandom);
         if (k < 2 && $urandom_range(0, 1) == 1) rf = 3'b010;
         if (k == 4 && $urandom_range(0, 1) == 1) rf = 3'($urandom_range(0, 1));
         run_instr($sformatf("brnd%0d", i), ro, rf, 1'($urandom), 1'($urandom), 1'b0,
                   0, 0, 1'b1, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
